// File: rtl/basic.sv
// Smoke-test top: a minimal two-phase 8-bit controller core, its hard-coded
// program ROM and a latched output-port register.
module basic #(
  parameter int ADDR_W   = 10,
  parameter int NUM_REGS = 16
) (
  input logic CLK_IN,
  input logic RESET_IN
);

  // state    | meaning
  // PH_FETCH | latch ROM[pc] into instr
  // PH_EXEC  | apply instr, advance or redirect pc
  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_EXEC  = 1'b1
  } phase_e;

  localparam logic [5:0] OP_LOAD_K = 6'h00;
  localparam logic [5:0] OP_LOAD_R = 6'h01;
  localparam logic [5:0] OP_ADD_K  = 6'h18;
  localparam logic [5:0] OP_ADD_R  = 6'h19;
  localparam logic [5:0] OP_OUTPUT = 6'h2C;
  localparam logic [5:0] OP_JUMP   = 6'h34;

  logic [ADDR_W-1:0] pc;
  logic [17:0]       instr;
  phase_e            phase;
  logic [7:0]        regs [NUM_REGS];
  logic              zero_flag;
  logic              carry_flag;
  logic [7:0]        port_id;
  logic [7:0]        out_port;
  logic              write_strobe;
  logic [7:0]        port_reg;

  logic [17:0] rom_word;

  function automatic logic [17:0] rom_lookup(input logic [ADDR_W-1:0] addr);
    logic [17:0] word;
    case (addr)
      ADDR_W'(1): word = 18'h18001;  // ADD    s0,0x01
      ADDR_W'(2): word = 18'h2C000;  // OUTPUT s0,0x00
      ADDR_W'(3): word = 18'h34001;  // JUMP   0x001
      default:    word = 18'h00000;  // LOAD   s0,0x00
    endcase
    return word;
  endfunction

  assign rom_word = rom_lookup(pc);

  logic [5:0]        opcode;
  logic [3:0]        x_idx;
  logic [3:0]        y_idx;
  logic [7:0]        kk;
  logic [7:0]        x_val;
  logic [7:0]        y_val;
  logic [7:0]        add_operand;
  logic [8:0]        sum_d;
  logic [ADDR_W-1:0] pc_inc_d;

  assign opcode      = instr[17:12];
  assign x_idx       = instr[11:8];
  assign y_idx       = instr[7:4];
  assign kk          = instr[7:0];
  assign x_val       = regs[x_idx];
  assign y_val       = regs[y_idx];
  assign add_operand = (opcode == OP_ADD_R) ? y_val : kk;
  assign sum_d       = {1'b0, x_val} + {1'b0, add_operand};
  assign pc_inc_d    = pc + ADDR_W'(1);

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      pc           <= '0;
      instr        <= '0;
      phase        <= PH_FETCH;
      zero_flag    <= 1'b0;
      carry_flag   <= 1'b0;
      port_id      <= 8'h00;
      out_port     <= 8'h00;
      write_strobe <= 1'b0;
      port_reg     <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      write_strobe <= 1'b0;
      case (phase)
        PH_FETCH: begin
          instr <= rom_word;
          phase <= PH_EXEC;
        end
        PH_EXEC: begin
          phase <= PH_FETCH;
          pc    <= pc_inc_d;
          case (opcode)
            OP_LOAD_K: regs[x_idx] <= kk;
            OP_LOAD_R: regs[x_idx] <= y_val;
            OP_ADD_K, OP_ADD_R: begin
              regs[x_idx] <= sum_d[7:0];
              carry_flag  <= sum_d[8];
              zero_flag   <= (sum_d[7:0] == 8'h00);
            end
            OP_OUTPUT: begin
              port_id      <= kk;
              out_port     <= x_val;
              write_strobe <= 1'b1;
              if (kk == 8'h00) port_reg <= x_val;
            end
            OP_JUMP: pc <= instr[ADDR_W-1:0];
            default: ;
          endcase
        end
        default: phase <= PH_FETCH;
      endcase
    end
  end

  // Observation-only state has no on-chip consumer; fold it into one sink.
  logic unused_obs;
  assign unused_obs = ^{port_reg, port_id, out_port, write_strobe, zero_flag};

endmodule

// File: tb/tb_basic.sv
// Scoreboard bench for basic: a cycle model predicts each port write, the
// monitor pops and compares when write_strobe is seen.
module tb_basic;

  logic CLK_IN;
  logic RESET_IN;

  basic dut (
    .CLK_IN  (CLK_IN),
    .RESET_IN(RESET_IN)
  );

  initial CLK_IN = 1'b0;
  always #5 CLK_IN = ~CLK_IN;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         strobes = 0;
  logic [9:0] pc_max = '0;
  logic [7:0] model_cnt = 8'h00;
  logic [7:0] sb [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: predict, wait past the edge, then score.
  task automatic tick();
    logic       rst_at_edge;
    logic [7:0] e;
    rst_at_edge = RESET_IN;
    if (!rst_at_edge && ((cyc + 1) % 6 == 0)) begin
      model_cnt = model_cnt + 8'h01;
      sb.push_back(model_cnt);
    end
    @(posedge CLK_IN);
    #1;
    if (rst_at_edge) begin
      sb.delete();
      cyc       = 0;
      model_cnt = 8'h00;
    end else begin
      cyc++;
    end
    if (dut.pc > pc_max) pc_max = dut.pc;
    if (dut.write_strobe) begin
      strobes++;
      if (sb.size() == 0) begin
        check_val("spurious_strobe", 32'(dut.write_strobe), 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("out_port", 32'(dut.out_port), 32'(e));
        check_val("port_reg", 32'(dut.port_reg), 32'(e));
        check_val("port_id", 32'(dut.port_id), 32'h00);
        check_val("carry_at_write", 32'(dut.carry_flag), 32'(e == 8'h00));
        check_val("zero_at_write", 32'(dut.zero_flag), 32'(e == 8'h00));
      end
    end else if (sb.size() != 0) begin
      check_val("missing_strobe", 32'(dut.write_strobe), 32'd1);
      void'(sb.pop_front());
    end
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_pc"}, 32'(dut.pc), 32'd0);
    check_val({tag, "_phase"}, 32'(dut.phase), 32'd0);
    check_val({tag, "_zero"}, 32'(dut.zero_flag), 32'd0);
    check_val({tag, "_carry"}, 32'(dut.carry_flag), 32'd0);
    check_val({tag, "_port_id"}, 32'(dut.port_id), 32'd0);
    check_val({tag, "_out_port"}, 32'(dut.out_port), 32'd0);
    check_val({tag, "_strobe"}, 32'(dut.write_strobe), 32'd0);
    check_val({tag, "_port_reg"}, 32'(dut.port_reg), 32'd0);
    for (int r = 0; r < 16; r++) check_val($sformatf("%s_s%0h", tag, r), 32'(dut.regs[r]), 32'd0);
  endtask

  initial begin
    int base;
    int guard;
    RESET_IN = 1'b1;

    for (int i = 0; i < 100; i++) begin
      tick();
      check_val("rst_pc", 32'(dut.pc), 32'd0);
      check_val("rst_phase", 32'(dut.phase), 32'd0);
      check_val("rst_s0", 32'(dut.regs[0]), 32'd0);
      check_val("rst_port_reg", 32'(dut.port_reg), 32'd0);
      check_val("rst_strobe", 32'(dut.write_strobe), 32'd0);
    end
    check_cleared("reset_hold");

    RESET_IN = 1'b0;
    strobes  = 0;
    for (int i = 0; i < 6; i++) tick();
    check_val("strobes_first6", 32'(strobes), 32'd1);
    check_val("port_reg_first", 32'(dut.port_reg), 32'h01);

    pc_max = '0;
    for (int i = 0; i < 60; i++) tick();
    check_val("strobes_after66", 32'(strobes), 32'd11);
    check_val("port_reg_0b", 32'(dut.port_reg), 32'h0B);
    check_val("pc_max_le3", 32'(pc_max <= 10'h003), 32'd1);

    guard = 0;
    while (strobes < 256 && guard < 2000) begin
      tick();
      guard++;
    end
    check_val("strobes_256", 32'(strobes), 32'd256);
    check_val("wrap_port_reg", 32'(dut.port_reg), 32'h00);
    check_val("wrap_carry", 32'(dut.carry_flag), 32'd1);
    check_val("wrap_zero", 32'(dut.zero_flag), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    check_val("strobes_257", 32'(strobes), 32'd257);
    check_val("post_wrap_port_reg", 32'(dut.port_reg), 32'h01);
    check_val("post_wrap_carry", 32'(dut.carry_flag), 32'd0);
    check_val("post_wrap_zero", 32'(dut.zero_flag), 32'd0);

    guard = 0;
    while (!(dut.port_reg == 8'h05 && dut.phase == 1'b1) && guard < 100) begin
      tick();
      guard++;
    end
    check_val("reached_mid_exec", 32'(guard < 100), 32'd1);
    RESET_IN = 1'b1;
    tick();
    check_cleared("mid_reset");
    RESET_IN = 1'b0;
    base     = strobes;
    for (int i = 0; i < 6; i++) tick();
    check_val("restart_strobes", 32'(strobes - base), 32'd1);
    check_val("restart_port_reg", 32'(dut.port_reg), 32'h01);

    force dut.rom_word = 18'h3F5A7;
    RESET_IN = 1'b1;
    tick();
    RESET_IN = 1'b0;
    tick();
    check_val("nop_phase_exec", 32'(dut.phase), 32'd1);
    tick();
    check_val("nop_pc", 32'(dut.pc), 32'h001);
    check_val("nop_phase", 32'(dut.phase), 32'd0);
    check_val("nop_zero", 32'(dut.zero_flag), 32'd0);
    check_val("nop_carry", 32'(dut.carry_flag), 32'd0);
    check_val("nop_strobe", 32'(dut.write_strobe), 32'd0);
    check_val("nop_port_reg", 32'(dut.port_reg), 32'd0);
    for (int r = 0; r < 16; r++) check_val($sformatf("nop_s%0h", r), 32'(dut.regs[r]), 32'd0);
    release dut.rom_word;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/basic.md
Name: basic

Overview:
- Self-contained demonstration system: a minimal PicoBlaze-style 8-bit microcontroller core plus a hard-coded program ROM and one output-port register.
- Only primary inputs are clock and reset; there are no primary outputs.
- All results are observed through the named internal signals listed under Behaviour; the bench probes them hierarchically.
- Used as the smoke-test top level for bringing up the processor flow.

Parameters:
- ADDR_W, 10, program-counter / ROM address width (ROM depth 2^ADDR_W, 18-bit words).
- NUM_REGS, 16, number of 8-bit general registers s0..sF.

Ports:
- CLK_IN  input  1  system clock, 100 MHz nominal; all state on rising edge.
- RESET_IN  input  1  one clock; reset is synchronous and active-high.

Behaviour:
- Internal observable signals (fixed names):
  - pc[ADDR_W-1:0]
  - instr[17:0]
  - phase (0 = fetch, 1 = execute)
  - regs s0..sF
  - zero_flag, carry_flag
  - port_id[7:0], out_port[7:0], write_strobe
  - port_reg[7:0]: latched output-port value
- Reset (RESET_IN high at a rising edge):
  - pc=0, phase=0, all regs=0x00, flags=0.
  - port_id=0, out_port=0, write_strobe=0, port_reg=0x00.
  - Reset overrides everything, including mid-instruction; it may be held for any length.
- Each instruction takes exactly 2 clocks:
  - Fetch: instr <= ROM[pc]; phase <= 1.
  - Execute: apply the instruction; pc <= next pc; phase <= 0.
- Encoding: opcode = instr[17:12], X = instr[11:8], Y = instr[7:4], kk = instr[7:0], aaa = instr[ADDR_W-1:0].
- Opcodes:
  - 0x00 LOAD sX,kk: sX <= kk; flags unchanged.
  - 0x01 LOAD sX,sY: sX <= sY; flags unchanged.
  - 0x18 ADD sX,kk: {carry,sX} <= sX+kk, 9-bit sum; zero <= (result[7:0]==0).
  - 0x19 ADD sX,sY: same as ADD sX,kk with sY as operand.
  - 0x2C OUTPUT sX,pp: port_id <= kk; out_port <= sX; write_strobe <= 1 for that single execute-cycle edge; port_reg <= sX when pp==0x00.
  - 0x34 JUMP aaa: pc <= aaa.
  - Any other opcode: NOP (pc+1, no state change).
- Next pc is pc+1 modulo 2^ADDR_W (wraps from 0x3FF to 0x000); JUMP overrides it.
- write_strobe is 0 in all other cycles.
- Addition wraps modulo 256; carry records bit 8.
- ROM contents (combinational or registered read; the fetch cycle hides the latency):
  - 0x000 LOAD s0,0x00
  - 0x001 ADD s0,0x01
  - 0x002 OUTPUT s0,0x00
  - 0x003 JUMP 0x001
  - All other words 0x00000 (LOAD s0,0x00).
- Program effect: port_reg counts 1,2,3,…,255,0,1,…
  - One increment per 6 clocks (3 instructions × 2 clocks).
  - First write occurs at the 6th rising edge after the first edge with RESET_IN low.
  - carry_flag=1 and zero_flag=1 after the ADD that wraps 0xFF→0x00; both flags are 0 after every other ADD in the loop.

Test Plan:
- Hold RESET_IN high 100 cycles (100 ns–1100 ns) -> pc=0, phase=0, s0=0, port_reg=0x00, write_strobe=0 throughout.
- Release reset, run 6 cycles -> write_strobe pulses once on cycle 6 with port_id=0x00, out_port=0x01; port_reg=0x01.
- Run 60 further cycles -> exactly 10 more strobes, spaced 6 cycles apart; port_reg=0x0B; pc never exceeds 0x003.
- Run until 256 writes total -> port_reg=0x00, carry_flag=1, zero_flag=1; the next write gives 0x01 with both flags 0.
- Assert RESET_IN for 1 cycle mid-execute (phase=1) while port_reg=0x05 -> next edge: all state cleared; the sequence restarts with the first write of 0x01 six cycles after release.
- Bench-forced ROM image containing opcode 0x3F at 0x000 -> treated as NOP; pc advances to 0x001 after 2 cycles; regs and flags unchanged.
